// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with 2-flop input synchronizer and single mid-bit sampling
module uart_rx #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_rx_meta;
  logic            r_rx_sync;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data_out;
  logic            r_data_valid;
  logic            r_framing_error;
  logic            w_cnt_full;
  logic            w_cnt_half;

  assign w_cnt_full = (r_clk_cnt == LP_FULL);
  assign w_cnt_half = (r_clk_cnt == LP_HALF);

  // Idle-high line: both flops reset to 1 so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (!r_rx_sync) w_next_state = S_START;
      S_START:     if (w_cnt_half) w_next_state = r_rx_sync ? S_IDLE : S_DATA;
      S_DATA:      if (w_cnt_full && (r_bit_idx == 3'd7)) w_next_state = S_STOP;
      S_STOP:      if (w_cnt_full) w_next_state = r_rx_sync ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (r_rx_sync) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_cnt       <= '0;
      r_bit_idx       <= 3'd0;
      r_shift         <= 8'h00;
      r_data_out      <= 8'h00;
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
      case (r_state)
        S_START: begin
          if (w_cnt_half) begin
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_cnt_full) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= r_rx_sync;
            r_bit_idx          <= r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_cnt_full) begin
            r_clk_cnt <= '0;
            if (r_rx_sync) begin
              r_data_out   <= r_shift;
              r_data_valid <= 1'b1;
            end else begin
              r_framing_error <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: begin
          r_clk_cnt <= '0;
          r_bit_idx <= 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    busy          = (r_state != S_IDLE);
    data_out      = r_data_out;
    data_valid    = r_data_valid;
    framing_error = r_framing_error;
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx with a byte scoreboard fed by a bit-level transmitter
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] sb[$];
  int pulse_cyc[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .framing_error(framing_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every data_valid pulse.
  initial begin
    logic       prev_dv;
    logic       prev_fe;
    logic [7:0] exp_b;
    prev_dv = 1'b0;
    prev_fe = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (data_valid) begin
          dv_cnt++;
          pulse_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            check("spurious_valid", {24'h0, data_out}, 32'h100);
          end else begin
            exp_b = sb.pop_front();
            check("rx_byte", {24'h0, data_out}, {24'h0, exp_b});
          end
          if (prev_dv) check("dv_one_cycle", 32'd2, 32'd1);
        end
        if (framing_error) begin
          fe_cnt++;
          if (prev_fe) check("fe_one_cycle", 32'd2, 32'd1);
        end
        if (data_valid && framing_error) check("dv_fe_overlap", 32'd1, 32'd0);
        prev_dv = data_valid;
        prev_fe = framing_error;
      end else begin
        prev_dv = 1'b0;
        prev_fe = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int nbits);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    if (stop && nbits == 10) sb.push_back(b);
    for (int i = 0; i < nbits; i++) begin
      rx = frame[i];
      repeat (CPB) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_c;
    int n0;
    int dvb;
    int feb;
    logic saw_busy;

    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) tick();
    check("reset_data_out", {24'h0, data_out}, 32'h00);
    check("reset_dv", {31'h0, data_valid}, 32'h0);
    check("reset_fe", {31'h0, framing_error}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Loopback 0xB7 with latency measurement from first low sample.
    n0 = pulse_cyc.size();
    feb = fe_cnt;
    start_c = cyc + 1;
    send(8'hB7, 1'b1, 10);
    repeat (2) tick();
    check("b7_pulses", pulse_cyc.size(), n0 + 1);
    if (pulse_cyc.size() > n0) check("latency", pulse_cyc[n0] - start_c, 32'd78);
    check("b7_data", {24'h0, data_out}, 32'hB7);
    check("b7_no_fe", fe_cnt, feb);
    check("b7_busy_low", {31'h0, busy}, 32'h0);

    // Back-to-back frames with no idle gap.
    n0 = pulse_cyc.size();
    send(8'h55, 1'b1, 10);
    send(8'hAA, 1'b1, 10);
    repeat (4) tick();
    check("b2b_pulses", pulse_cyc.size(), n0 + 2);
    if (pulse_cyc.size() >= n0 + 2) check("b2b_spacing", pulse_cyc[n0 + 1] - pulse_cyc[n0], 32'd80);
    check("b2b_last", {24'h0, data_out}, 32'hAA);

    // Two-cycle glitch is rejected as a false start.
    dvb = dv_cnt;
    feb = fe_cnt;
    saw_busy = 1'b0;
    rx = 1'b0;
    tick();
    tick();
    rx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      saw_busy |= busy;
      tick();
    end
    check("glitch_busy_seen", {31'h0, saw_busy}, 32'h1);
    check("glitch_busy_low", {31'h0, busy}, 32'h0);
    check("glitch_no_dv", dv_cnt, dvb);
    check("glitch_no_fe", fe_cnt, feb);
    check("glitch_data", {24'h0, data_out}, 32'hAA);

    // Bad stop bit followed by a 40-cycle break.
    dvb = dv_cnt;
    feb = fe_cnt;
    send(8'h3C, 1'b0, 10);
    repeat (32) tick();
    check("frm_fe_pulse", fe_cnt, feb + 1);
    check("frm_no_dv", dv_cnt, dvb);
    check("frm_data", {24'h0, data_out}, 32'hAA);
    check("frm_busy_held", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    repeat (4) tick();
    check("frm_busy_released", {31'h0, busy}, 32'h0);
    send(8'h81, 1'b1, 10);
    repeat (2) tick();
    check("frm_recover", {24'h0, data_out}, 32'h81);
    check("frm_recover_dv", dv_cnt, dvb + 1);

    // Reset asserted during bit 4 of 0xF0.
    send(8'hF0, 1'b1, 5);
    rx = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", {24'h0, data_out}, 32'h00);
    check("mid_rst_dv", {31'h0, data_valid}, 32'h0);
    check("mid_rst_fe", {31'h0, framing_error}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    dvb = dv_cnt;
    send(8'h0F, 1'b1, 10);
    repeat (2) tick();
    check("post_rst_data", {24'h0, data_out}, 32'h0F);
    check("post_rst_single_dv", dv_cnt, dvb + 1);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 8, clock cycles per serial bit; legal values even, >= 4.
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: rx  input  1  serial line, idle high, asynchronous to clk; frame 8N1, LSB first, matching the team's UART transmitter.
REQ-005 SHALL have port: data_out  output  8  last correctly framed byte; held until next good frame.
REQ-006 SHALL have port: data_valid  output  1  one-cycle pulse, data_out updated this cycle.
REQ-007 SHALL have port: framing_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 SHALL have port: busy  output  1  high whenever state != IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer (rx_sync); both flops reset to 1; no logic uses raw rx.
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH; bit counter clk_cnt of $clog2(CLKS_PER_BIT) bits; bit_idx 3 bits; shift register 8 bits.
REQ-011 IDLE: rx_sync==0 -> START, clk_cnt=0; else stay.
REQ-012 START: increment clk_cnt until clk_cnt==CLKS_PER_BIT/2-1; on that edge sample rx_sync: 0 -> DATA, clk_cnt=0, bit_idx=0; 1 -> IDLE (false start, no pulse output).
REQ-013 DATA: increment clk_cnt until clk_cnt==CLKS_PER_BIT-1; on that edge write rx_sync to shift[bit_idx], clk_cnt=0; bit_idx==7 -> STOP, else bit_idx+1.
REQ-014 STOP: on clk_cnt==CLKS_PER_BIT-1 sample rx_sync: 1 -> data_out<=shift, data_valid=1 next cycle, -> IDLE; 0 -> framing_error=1 next cycle, data_out unchanged, -> WAIT_HIGH.
REQ-015 WAIT_HIGH: stay until rx_sync==1, then -> IDLE; a held-low (break) line SHALL never start a new frame.
REQ-016 data_valid and framing_error SHALL each be high exactly one cycle per frame, never both in the same cycle.
REQ-017 Latency: with first rx-low sample at edge 0, stop bit sampled at edge 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (78 for CLKS_PER_BIT=8); pulse visible immediately after that edge.
REQ-018 From IDLE, a new start bit SHALL be accepted on the cycle after returning to IDLE (back-to-back frames, no gap required beyond one stop bit).
REQ-019 rx transitions during a bit period other than at the sample point SHALL not affect the result (single mid-bit sample).

Reset
REQ-020 reset_n low SHALL immediately force: state=IDLE, clk_cnt=0, bit_idx=0, shift=0, data_out=8'h00, data_valid=0, framing_error=0, busy=0, synchronizer flops=1.
REQ-021 Reset asserted mid-frame SHALL discard the partial byte with no pulse; after release the block SHALL wait for rx_sync high-to-low before starting a frame only if line is low -> treated as start (per REQ-011).

Verification
REQ-022 Loopback: UART transmitter (CLKS_PER_BIT=8) tx -> rx, send 8'hB7 -> data_out=8'hB7, data_valid one cycle, framing_error 0, busy low afterwards.
REQ-023 Back-to-back: transmit 8'h55 then 8'hAA with no idle gap -> two data_valid pulses, values 8'h55 then 8'hAA, 80 cycles apart.
REQ-024 Glitch: drive rx low for 2 cycles, then high -> busy rises then falls within 6 cycles, no data_valid, no framing_error, data_out unchanged.
REQ-025 Framing: frame 8'h3C with stop bit driven 0 and line held low 40 cycles -> framing_error one pulse, no data_valid, data_out unchanged, busy stays high until rx returns high, then next good frame 8'h81 received correctly.
REQ-026 Reset mid-frame: assert reset_n low during bit 4 of 8'hF0 -> all outputs 0 immediately; after release and rx high, frame 8'h0F -> data_out=8'h0F, single data_valid.
REQ-027 Latency check: CLKS_PER_BIT=8, count edges from first rx-low sample to data_valid -> exactly 78.
